board_pixel_gen: RTL and testbench

//  Upstream pixel source for vga_driver: converts the driver's next_x/next_y request into the
//  8-bit RRRGGGBB colour on color_out, wired to vga_driver.color_in. Renders a COLS x ROWS game

---
 rtl/vga_pkg.sv | 34 +++
 rtl/board_pixel_gen_if.sv | 18 +
 rtl/board_pixel_gen_cell_locator.sv | 42 ++++
 rtl/board_pixel_gen.sv | 136 +++++++++++++
 tb/tb_board_pixel_gen.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the board pixel generator: RRRGGGBB colour
// type, board cell codes and the fixed palette used on screen.
package vga_pkg;

  typedef logic [7:0] color_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    P1     = 2'd1,
    P2     = 2'd2,
    HILITE = 2'd3
  } cell_t;

  localparam color_t COL_BG     = 8'h00;
  localparam color_t COL_GRID   = 8'h03;
  localparam color_t COL_P1     = 8'hE0;
  localparam color_t COL_P2     = 8'hFC;
  localparam color_t COL_HILITE = 8'h1C;
  localparam color_t COL_CURSOR = 8'h92;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  // Palette lookup for an occupied cell; EMPTY maps to background.
  function automatic color_t piece_color(input cell_t c);
    case (c)
      P1:      piece_color = COL_P1;
      P2:      piece_color = COL_P2;
      HILITE:  piece_color = COL_HILITE;
      default: piece_color = COL_BG;
    endcase
  endfunction

endpackage

// File: rtl/board_pixel_gen_if.sv
// Board write port: game logic (master) writes one cell per cycle or clears
// the whole board; the board (slave) answers with ack/err pulses.
interface board_pixel_gen_if;
  import vga_pkg::*;

  logic  clear;
  logic  wr_en;
  logic  [2:0] wr_col;
  logic  [2:0] wr_row;
  cell_t wr_data;
  logic  wr_ack;
  logic  wr_err;

  modport master (output clear, wr_en, wr_col, wr_row, wr_data,
                  input  wr_ack, wr_err);
  modport slave  (input  clear, wr_en, wr_col, wr_row, wr_data,
                  output wr_ack, wr_err);
endinterface

// File: rtl/board_pixel_gen_cell_locator.sv
// Combinational pixel-to-cell mapping: which board cell a screen pixel falls
// in, whether it lies inside the board rectangle, and whether it is a grid line
// (including the closing right/bottom band).
module cell_locator #(
  parameter int COLS   = 7,
  parameter int ROWS   = 6,
  parameter int CELL_W = 64,
  parameter int CELL_H = 64,
  parameter int ORG_X  = 96,
  parameter int ORG_Y  = 48,
  parameter int LINE_W = 2
) (
  input  logic [9:0] next_x,
  input  logic [9:0] next_y,
  output logic [2:0] col,
  output logic [2:0] row,
  output logic       in_board,
  output logic       on_grid
);

  localparam int GRID_W  = COLS * CELL_W;
  localparam int GRID_H  = ROWS * CELL_H;
  localparam int BOARD_W = GRID_W + LINE_W;
  localparam int BOARD_H = GRID_H + LINE_W;

  logic [10:0] dx;
  logic [10:0] dy;

  // Offsets from the board origin; only meaningful when in_board is set.
  always_comb begin
    dx       = {1'b0, next_x} - 11'(ORG_X);
    dy       = {1'b0, next_y} - 11'(ORG_Y);
    in_board = ({1'b0, next_x} >= 11'(ORG_X)) && (dx < 11'(BOARD_W)) &&
               ({1'b0, next_y} >= 11'(ORG_Y)) && (dy < 11'(BOARD_H));
    col      = 3'(dx / 11'(CELL_W));
    row      = 3'(dy / 11'(CELL_H));
    on_grid  = ((dx % 11'(CELL_W)) < 11'(LINE_W)) ||
               ((dy % 11'(CELL_H)) < 11'(LINE_W)) ||
               (dx >= 11'(GRID_W)) || (dy >= 11'(GRID_H));
  end

endmodule

// File: rtl/board_pixel_gen.sv
// Pixel source for vga_driver: renders the game board (grid, pieces, cursor)
// with one cycle of latency and holds the board state written by game logic.
// Optional feature macro: CURSOR_BLINK_EN -- when defined the cursor blinks
// every BLINK_FRAMES frames; otherwise the cursor is shown continuously.
module board_pixel_gen
  import vga_pkg::*;
#(
  parameter int COLS         = 7,
  parameter int ROWS         = 6,
  parameter int CELL_W       = 64,
  parameter int CELL_H       = 64,
  parameter int ORG_X        = 96,
  parameter int ORG_Y        = 48,
  parameter int LINE_W       = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] next_x,
  input  logic [9:0] next_y,
  output color_t     color_out,
  output logic       frame_start,
  input  logic [2:0] cur_col,
  input  logic [2:0] cur_row,
  board_pixel_gen_if.slave wr
);

  logic [2:0] col, row;
  logic       in_board, on_grid;
  cell_t      cells [ROWS][COLS];
  cell_t      cell_rd;
  logic [2:0] cur_col_q, cur_row_q;
  logic [9:0] prev_y;
  logic       frame_hit;
  logic       blink_on;
  logic       wr_in_range;
  color_t     color_p0;
  color_t     color_p1;

  cell_locator #(
    .COLS(COLS), .ROWS(ROWS), .CELL_W(CELL_W), .CELL_H(CELL_H),
    .ORG_X(ORG_X), .ORG_Y(ORG_Y), .LINE_W(LINE_W)
  ) u_locator (
    .next_x(next_x), .next_y(next_y),
    .col(col), .row(row), .in_board(in_board), .on_grid(on_grid)
  );

  assign frame_hit   = (next_y == 10'd0) && (prev_y != 10'd0);
  assign wr_in_range = (int'(wr.wr_col) < COLS) && (int'(wr.wr_row) < ROWS);

  // Stage p0: classify the requested pixel against the current board state.
  always_comb begin
    cell_rd  = EMPTY;
    color_p0 = COL_BG;
    if ((int'(col) < COLS) && (int'(row) < ROWS)) cell_rd = cells[row][col];
    if (in_board) begin
      if (on_grid)
        color_p0 = COL_GRID;
      else if (cell_rd != EMPTY)
        color_p0 = piece_color(cell_rd);
      else if ((col == cur_col_q) && (row == cur_row_q) && blink_on)
        color_p0 = COL_CURSOR;
    end
  end

  // Stage p1: registered colour, frame-start detection and cursor latch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      color_p1    <= COL_BG;
      prev_y      <= '0;
      frame_start <= 1'b0;
      cur_col_q   <= '0;
      cur_row_q   <= '0;
    end else begin
      color_p1    <= color_p0;
      prev_y      <= next_y;
      frame_start <= frame_hit;
      if (frame_hit) begin
        cur_col_q <= cur_col;
        cur_row_q <= cur_row;
      end
    end
  end

  assign color_out = color_p1;

  // Board state: clear beats a concurrent write, which is then reported as rejected.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr.wr_ack <= 1'b0;
      wr.wr_err <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          cells[r][c] <= EMPTY;
    end else begin
      wr.wr_ack <= 1'b0;
      wr.wr_err <= 1'b0;
      if (wr.clear) begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            cells[r][c] <= EMPTY;
        wr.wr_err <= wr.wr_en;
      end else if (wr.wr_en) begin
        if (wr_in_range) begin
          cells[wr.wr_row][wr.wr_col] <= wr.wr_data;
          wr.wr_ack <= 1'b1;
        end else begin
          wr.wr_err <= 1'b1;
        end
      end
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FC_W-1:0] frame_cnt;

  // Blink timer: toggle cursor visibility every BLINK_FRAMES frame starts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_hit) begin
      if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  assign blink_on = 1'b1;
`endif

endmodule

// File: tb/tb_board_pixel_gen.sv
// Directed bench for board_pixel_gen: reset state, grid sweeps, cell writes,
// write rejection, clear priority, cursor blink/latching and async reset.
module tb_board_pixel_gen;
  import vga_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] next_x, next_y;
  color_t     color_out;
  logic       frame_start;
  logic [2:0] cur_col, cur_row;

  int n_assert = 0;
  int n_fail   = 0;

  board_pixel_gen_if wr_bus ();

  board_pixel_gen dut (
    .clock(clock), .reset(reset),
    .next_x(next_x), .next_y(next_y),
    .color_out(color_out), .frame_start(frame_start),
    .cur_col(cur_col), .cur_row(cur_row),
    .wr(wr_bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Request one pixel; its colour is valid on return.
  task automatic pix(input int x, input int y);
    next_x = 10'(x);
    next_y = 10'(y);
    tick();
  endtask

  task automatic wr_set(input logic en, input int c, input int r, input cell_t d);
    wr_bus.wr_en   = en;
    wr_bus.wr_col  = 3'(c);
    wr_bus.wr_row  = 3'(r);
    wr_bus.wr_data = d;
  endtask

  initial begin
    int g, b, fs;
    logic [31:0] e;
    reset = 1'b1;
    next_x = '0; next_y = '0; cur_col = '0; cur_row = '0;
    wr_bus.clear = 1'b0;
    wr_set(1'b0, 0, 0, EMPTY);
    #3;
    chk("rst_color", 32'(color_out), 'h00);
    chk("rst_fs", 32'(frame_start), 0);
    chk("rst_ack", 32'(wr_bus.wr_ack), 0);
    chk("rst_err", 32'(wr_bus.wr_err), 0);
    @(negedge clock) reset = 1'b0;

    // Empty board: grid corners and edges
    pix(96, 48);   chk("grid_origin", 32'(color_out), 'h03);
    pix(545, 100); chk("grid_right_band", 32'(color_out), 'h03);
    pix(546, 100); chk("right_outside", 32'(color_out), 'h00);
    pix(95, 48);   chk("left_outside", 32'(color_out), 'h00);
    pix(300, 433); chk("grid_bottom_band", 32'(color_out), 'h03);
    pix(300, 434); chk("bottom_outside", 32'(color_out), 'h00);

    g = 0; b = 0; fs = 0;
    for (int x = 0; x < 640; x++) begin
      pix(x, 200);
      if (color_out === 8'h03) g++;
      else if (color_out === 8'h00) b++;
      fs += int'(frame_start);
    end
    chk("row200_grid", g, 16);
    chk("row200_bg", b, 624);
    g = 0; b = 0;
    for (int y = 1; y < 480; y++) begin
      pix(300, y);
      if (color_out === 8'h03) g++;
      else if (color_out === 8'h00) b++;
      fs += int'(frame_start);
    end
    chk("col300_grid", g, 14);
    chk("col300_bg", b, 465);
    chk("no_fs_before_wrap", fs, 0);
    pix(0, 0); chk("fs_on_wrap", 32'(frame_start), 1);
    pix(0, 0); chk("fs_one_cycle", 32'(frame_start), 0);

    // Single write and readback
    pix(234, 122); chk("cell21_empty", 32'(color_out), 'h00);
    wr_set(1'b1, 2, 1, P1); tick();
    chk("wr_ack", 32'(wr_bus.wr_ack), 1);
    chk("wr_no_err", 32'(wr_bus.wr_err), 0);
    wr_set(1'b0, 0, 0, EMPTY);
    pix(234, 122); chk("cell21_p1", 32'(color_out), 'hE0);
    chk("wr_ack_drop", 32'(wr_bus.wr_ack), 0);

    // Same-cycle write and display read shows the old value
    wr_set(1'b1, 3, 0, P2); pix(298, 58);
    chk("same_cycle_old", 32'(color_out), 'h00);
    wr_set(1'b0, 0, 0, EMPTY);
    pix(298, 58); chk("same_cycle_new", 32'(color_out), 'hFC);

    // Back-to-back writes
    wr_set(1'b1, 0, 5, HILITE); tick(); chk("b2b_ack0", 32'(wr_bus.wr_ack), 1);
    wr_set(1'b1, 6, 5, P2);     tick(); chk("b2b_ack1", 32'(wr_bus.wr_ack), 1);
    wr_set(1'b0, 0, 0, EMPTY);  tick(); chk("b2b_ack_end", 32'(wr_bus.wr_ack), 0);
    pix(106, 378); chk("cell05_hilite", 32'(color_out), 'h1C);
    pix(490, 378); chk("cell65_p2", 32'(color_out), 'hFC);

    // Out-of-range write is rejected
    wr_set(1'b1, 7, 0, P2); tick();
    chk("oor_err", 32'(wr_bus.wr_err), 1);
    chk("oor_no_ack", 32'(wr_bus.wr_ack), 0);
    wr_set(1'b0, 0, 0, EMPTY);
    pix(234, 122); chk("oor_cell21_kept", 32'(color_out), 'hE0);
    chk("oor_err_drop", 32'(wr_bus.wr_err), 0);

    // Clear wins over a simultaneous write
    wr_bus.clear = 1'b1; wr_set(1'b1, 4, 2, P1); tick();
    chk("clr_err", 32'(wr_bus.wr_err), 1);
    chk("clr_no_ack", 32'(wr_bus.wr_ack), 0);
    wr_bus.clear = 1'b0; wr_set(1'b0, 0, 0, EMPTY);
    pix(234, 122); chk("clr_cell21", 32'(color_out), 'h00);
    pix(362, 186); chk("clr_cell42_dropped", 32'(color_out), 'h00);
    pix(106, 378); chk("clr_cell05", 32'(color_out), 'h00);
    pix(298, 58);  chk("clr_cell30", 32'(color_out), 'h00);

    // Asynchronous reset mid-line
    wr_set(1'b1, 2, 1, P1); tick(); wr_set(1'b0, 0, 0, EMPTY);
    pix(234, 122); chk("pre_rst_p1", 32'(color_out), 'hE0);
    #2 reset = 1'b1;
    #1 chk("async_rst_color", 32'(color_out), 'h00);
    @(negedge clock) reset = 1'b0;
    pix(234, 122); chk("post_rst_cell21", 32'(color_out), 'h00);

    // Cursor over 61 frames
    for (int f = 0; f < 61; f++) begin
`ifdef CURSOR_BLINK_EN
      e = (((f / 30) % 2) == 0) ? 32'h92 : 32'h00;
`else
      e = 32'h92;
`endif
      pix(110, 60); chk($sformatf("cursor_f%0d", f), 32'(color_out), e);
      pix(0, 0);    chk($sformatf("fs_f%0d", f), 32'(frame_start), 1);
    end

    // Cursor change takes effect only at the next frame start
    cur_col = 3'd3; cur_row = 3'd0;
    pix(110, 60); chk("cur_hold_old", 32'(color_out), 'h92);
    pix(298, 58); chk("cur_hold_new_off", 32'(color_out), 'h00);
    pix(0, 0);    chk("cur_fs", 32'(frame_start), 1);
    pix(110, 60); chk("cur_moved_old_off", 32'(color_out), 'h00);
    pix(298, 58); chk("cur_moved_new_on", 32'(color_out), 'h92);

    // Out-of-range cursor matches no cell
    cur_col = 3'd7;
    pix(0, 0);    chk("cur_oor_fs", 32'(frame_start), 1);
    pix(298, 58); chk("cur_oor_c3", 32'(color_out), 'h00);
    pix(110, 60); chk("cur_oor_c0", 32'(color_out), 'h00);
    pix(0, 0);    chk("cur_oor_fs2", 32'(frame_start), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
